// File: rtl/capture_sequencer.sv
// Acquisition sequencer around the sample FIFO: flush, pre-trigger fill, armed wait,
// post-trigger count, then hands the FIFO to the host readout port.
module capture_sequencer #(
    parameter int CNT_W      = 16,
    parameter int FLUSH_CYC  = 4,
    parameter bit AUTO_REARM = 1'b0
) (
    input  logic             adc_dco,
    input  logic             reset,
    input  logic             arm,
    input  logic             sample_en,
    input  logic             trig,
    input  logic             force_trig,
    input  logic [CNT_W-1:0] pre_len,
    input  logic [CNT_W-1:0] post_len,
    input  logic             host_ready,
    input  logic             fifo_empty,
    input  logic             fifo_full,
    output logic             fifo_reset,
    output logic             fifo_wren,
    output logic             fifo_rden,
    output logic [2:0]       state,
    output logic             done,
    output logic             overflow
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FLUSH     = 3'd1,
        S_PRE       = 3'd2,
        S_ARMED     = 3'd3,
        S_POST      = 3'd4,
        S_WAIT_HOST = 3'd5,
        S_READOUT   = 3'd6
    } state_t;

    localparam int FL_W = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
    localparam logic [FL_W-1:0] FLUSH_LAST = FL_W'(FLUSH_CYC - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_pre_len;
    logic [CNT_W-1:0] r_post_len;
    logic [FL_W-1:0]  r_flush_cnt;
    logic             r_fifo_reset;
    logic             r_rden;
    logic             r_done;
    logic             r_overflow;

    logic [CNT_W-1:0] w_post_target;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_wr_phase;
    logic             w_wren;
    logic             w_full_hit;
    logic             w_trigger;
    logic             w_readout_exit;

    // POST stops writing once its target is met, so a trigger-coincident sample with
    // post_len<=1 cannot produce an extra write in the following POST cycle.
    always_comb begin
        w_post_target  = (r_post_len == '0) ? CNT_W'(1) : r_post_len;
        w_wr_phase     = (r_state == S_PRE) || (r_state == S_ARMED) ||
                         ((r_state == S_POST) && (r_cnt < w_post_target));
        w_wren         = w_wr_phase & sample_en & ~fifo_full;
        w_full_hit     = w_wr_phase & sample_en & fifo_full;
        w_cnt_inc      = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);
        w_cnt_next     = w_wren ? w_cnt_inc : r_cnt;
        w_trigger      = (trig & sample_en) | force_trig;
        w_readout_exit = fifo_empty | ~host_ready;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:      if (arm) w_next_state = S_FLUSH;
            S_FLUSH:     if (r_flush_cnt == FLUSH_LAST) w_next_state = S_PRE;
            S_PRE:       if (w_cnt_next >= r_pre_len) w_next_state = S_ARMED;
            S_ARMED:     if (w_trigger) w_next_state = S_POST;
            S_POST:      if (w_cnt_next >= w_post_target) w_next_state = S_WAIT_HOST;
            S_WAIT_HOST: if (host_ready) w_next_state = S_READOUT;
            S_READOUT:   if (w_readout_exit) w_next_state = AUTO_REARM ? S_FLUSH : S_IDLE;
            default:     w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge adc_dco) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge adc_dco) begin
        if (reset) begin
            r_cnt        <= '0;
            r_pre_len    <= '0;
            r_post_len   <= '0;
            r_flush_cnt  <= '0;
            r_fifo_reset <= 1'b1;
            r_rden       <= 1'b0;
            r_done       <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_flush_cnt  <= (r_state == S_FLUSH) ? r_flush_cnt + FL_W'(1) : '0;
            r_fifo_reset <= (w_next_state == S_FLUSH);
            r_rden       <= (w_next_state == S_READOUT);
            r_done       <= (r_state == S_READOUT) && w_readout_exit;

            if (r_state == S_FLUSH) begin
                r_overflow <= 1'b0;
            end else if (w_full_hit) begin
                r_overflow <= 1'b1;
            end

            case (r_state)
                S_FLUSH: begin
                    r_cnt <= '0;
                    if (w_next_state == S_PRE) begin
                        r_pre_len  <= pre_len;
                        r_post_len <= post_len;
                    end
                end
                S_PRE:   r_cnt <= (w_next_state == S_ARMED) ? '0 : w_cnt_next;
                // Trigger-coincident sample is post sample #1.
                S_ARMED: if (w_next_state == S_POST) r_cnt <= w_wren ? CNT_W'(1) : '0;
                S_POST:  r_cnt <= w_cnt_next;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign state      = r_state;
    assign fifo_reset = r_fifo_reset;
    assign fifo_wren  = w_wren;
    assign fifo_rden  = r_rden;
    assign done       = r_done;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_capture_sequencer.sv
// Scoreboard bench for capture_sequencer: expected per-state segments are queued by the
// stimulus and checked by a monitor on every state change of the DUT.
module tb_capture_sequencer;

    logic        clk = 1'b0;
    logic        reset, arm, sample_en, trig, force_trig;
    logic [15:0] pre_len, post_len;
    logic        host_ready, fifo_empty, fifo_full;
    logic        fifo_reset, fifo_wren, fifo_rden, done, overflow;
    logic [2:0]  state;
    logic        a_fifo_reset, a_fifo_wren, a_fifo_rden, a_done, a_overflow;
    logic [2:0]  a_state;

    always #5 clk = ~clk;

    capture_sequencer #(.CNT_W(16), .FLUSH_CYC(4), .AUTO_REARM(1'b0)) dut (
        .adc_dco(clk), .reset(reset), .arm(arm), .sample_en(sample_en), .trig(trig),
        .force_trig(force_trig), .pre_len(pre_len), .post_len(post_len),
        .host_ready(host_ready), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .fifo_reset(fifo_reset), .fifo_wren(fifo_wren), .fifo_rden(fifo_rden),
        .state(state), .done(done), .overflow(overflow)
    );

    capture_sequencer #(.CNT_W(16), .FLUSH_CYC(4), .AUTO_REARM(1'b1)) dut_rearm (
        .adc_dco(clk), .reset(reset), .arm(arm), .sample_en(sample_en), .trig(trig),
        .force_trig(force_trig), .pre_len(pre_len), .post_len(post_len),
        .host_ready(host_ready), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
        .fifo_reset(a_fifo_reset), .fifo_wren(a_fifo_wren), .fifo_rden(a_fifo_rden),
        .state(a_state), .done(a_done), .overflow(a_overflow)
    );

    // One record per state exit: counts over the segment just left, values on entry to the next.
    // -1 means "not checked". alt = expected state of the AUTO_REARM instance at that moment.
    typedef struct {
        int from_s; int to_s; int cyc; int wren; int rden; int frst; int donec;
        int e_done; int e_ovf; int e_frst; int alt;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;

    int seg_cyc, seg_wren, seg_rden, seg_frst, seg_done, seg_awren, seg_arden;

    function automatic void chk(input string name, input int act, input int exp);
        if (exp < 0) return;
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void push(input int f, input int t, input int cyc, input int wren,
                                 input int rden, input int frst, input int donec,
                                 input int edone, input int eovf, input int efrst,
                                 input int alt);
        exp_t e;
        e.from_s = f; e.to_s = t; e.cyc = cyc; e.wren = wren; e.rden = rden;
        e.frst = frst; e.donec = donec; e.e_done = edone; e.e_ovf = eovf;
        e.e_frst = efrst; e.alt = alt;
        sb_q.push_back(e);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_sample(input logic t);
        sample_en = 1'b1; trig = t;
        tick();
        sample_en = 1'b0; trig = 1'b0;
        tick();
    endtask

    function automatic void seg_clear();
        seg_cyc = 0; seg_wren = 0; seg_rden = 0; seg_frst = 0;
        seg_done = 0; seg_awren = 0; seg_arden = 0;
    endfunction

    function automatic void seg_acc();
        seg_cyc++;
        seg_wren  += int'(fifo_wren);
        seg_rden  += int'(fifo_rden);
        seg_frst  += int'(fifo_reset);
        seg_done  += int'(done);
        seg_awren += int'(a_fifo_wren);
        seg_arden += int'(a_fifo_rden);
    endfunction

    // Monitor
    initial begin : monitor
        int   last_s;
        exp_t e;
        wait (mon_en);
        @(negedge clk);
        last_s = int'(state);
        seg_clear();
        seg_acc();
        forever begin
            @(negedge clk);
            if (int'(state) != last_s) begin
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_transition: got %0d->%0d, expected none",
                             last_s, state);
                end else begin
                    e = sb_q.pop_front();
                    chk("from_state", last_s, e.from_s);
                    chk("to_state", int'(state), e.to_s);
                    chk("seg_cycles", seg_cyc, e.cyc);
                    chk("seg_wren", seg_wren, e.wren);
                    chk("seg_rden", seg_rden, e.rden);
                    chk("seg_fifo_reset", seg_frst, e.frst);
                    chk("seg_done", seg_done, e.donec);
                    chk("entry_done", int'(done), e.e_done);
                    chk("entry_overflow", int'(overflow), e.e_ovf);
                    chk("entry_fifo_reset", int'(fifo_reset), e.e_frst);
                    chk("entry_rden", int'(fifo_rden), (e.to_s == 6) ? 1 : 0);
                    chk("rearm_state", int'(a_state), e.alt);
                    chk("rearm_done", int'(a_done), e.e_done);
                    chk("rearm_overflow", int'(a_overflow), e.e_ovf);
                    chk("rearm_fifo_reset", int'(a_fifo_reset), (e.alt == 1) ? 1 : e.e_frst);
                    chk("rearm_seg_wren", seg_awren, e.wren);
                    chk("rearm_seg_rden", seg_arden, e.rden);
                end
                last_s = int'(state);
                seg_clear();
            end
            seg_acc();
        end
    end

    // Stimulus
    initial begin : stimulus
        reset = 1'b1; arm = 1'b0; sample_en = 1'b0; trig = 1'b0; force_trig = 1'b0;
        pre_len = 16'd8; post_len = 16'd16;
        host_ready = 1'b0; fifo_empty = 1'b0; fifo_full = 1'b0;
        tick(); tick();
        chk("rst_state", int'(state), 0);
        chk("rst_fifo_reset", int'(fifo_reset), 1);
        chk("rst_rden", int'(fifo_rden), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_wren", int'(fifo_wren), 0);
        reset = 1'b0;
        tick(); tick();
        mon_en = 1'b1;
        tick();

        // Acquisition A: pre 8, 12 armed samples, trigger on the next, 16 post (36 writes),
        // then drain 36 reads.
        push(0, 1, -1,  0,  0, -1, 0,  0, 0, 1,  1);
        push(1, 2,  4,  0,  0,  4, 0,  0, 0, 0,  2);
        push(2, 3, 15,  8,  0,  0, 0,  0, 0, 0,  3);
        push(3, 4, 26, 13,  0,  0, 0,  0, 0, 0,  4);
        push(4, 5, 30, 15,  0,  0, 0,  0, 0, 0,  5);
        push(5, 6,  8,  0,  0,  0, 0,  0, 0, 0,  6);
        push(6, 0, 36,  0, 36,  0, 0,  1, 0, 0,  1);
        arm = 1'b1; tick(); arm = 1'b0;
        sample_en = 1'b1; repeat (4) tick(); sample_en = 1'b0;
        for (int i = 1; i <= 8; i++) send_sample((i == 3) || (i == 5));
        for (int i = 9; i <= 20; i++) send_sample(1'b0);
        send_sample(1'b1);
        for (int i = 22; i <= 36; i++) send_sample(1'b0);
        repeat (3) send_sample(1'b1);
        host_ready = 1'b1; tick();
        repeat (35) tick();
        fifo_empty = 1'b1; tick();
        fifo_empty = 1'b0; host_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b1; repeat (2) tick(); reset = 1'b0; repeat (2) tick();

        // Acquisition B: pre_len=0, post_len=0, arm held high, force trigger, host abort.
        pre_len = 16'd0; post_len = 16'd0;
        push(0, 1, -1,  0,  0, -1, 1,  0, 0, 1,  1);
        push(1, 2,  4,  0,  0,  4, 0,  0, 0, 0,  2);
        push(2, 3,  1,  0,  0,  0, 0,  0, 0, 0,  3);
        push(3, 4,  7,  3,  0,  0, 0,  0, 0, 0,  4);
        push(4, 5,  2,  1,  0,  0, 0,  0, 0, 0,  5);
        push(5, 6,  3,  0,  0,  0, 0,  0, 0, 0,  6);
        push(6, 0,  5,  0,  5,  0, 0,  1, 0, 0,  1);
        arm = 1'b1; tick();
        repeat (4) tick();
        tick();
        repeat (3) send_sample(1'b0);
        force_trig = 1'b1; tick(); force_trig = 1'b0;
        tick();
        send_sample(1'b0);
        arm = 1'b0; tick();
        host_ready = 1'b1; tick();
        repeat (4) tick();
        host_ready = 1'b0; tick();
        repeat (3) tick();
        reset = 1'b1; repeat (2) tick(); reset = 1'b0; repeat (2) tick();

        // Acquisition C: trigger together with fifo_full, 3 blocked post samples,
        // 4 good ones (target 5), then reset mid-POST.
        pre_len = 16'd2; post_len = 16'd5;
        push(0, 1, -1,  0,  0, -1, 1,  0, 0, 1,  1);
        push(1, 2,  4,  0,  0,  4, 0,  0, 0, 0,  2);
        push(2, 3,  3,  2,  0,  0, 0,  0, 0, 0,  3);
        push(3, 4,  2,  0,  0,  0, 0,  0, 1, 0,  4);
        push(4, 0, 15,  4,  0,  0, 0,  0, 0, 1,  0);
        arm = 1'b1; tick(); arm = 1'b0;
        repeat (4) tick();
        repeat (2) send_sample(1'b0);
        sample_en = 1'b1; trig = 1'b1; fifo_full = 1'b1; tick();
        sample_en = 1'b0; trig = 1'b0;
        repeat (3) send_sample(1'b0);
        fifo_full = 1'b0;
        repeat (4) send_sample(1'b0);
        reset = 1'b1; tick(); tick();
        reset = 1'b0; repeat (3) tick();

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick();
        chk("pending_expectations", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
